// File: rtl/pumpa_pkg.sv
// Shared definitions for the bottle-fill pump controller: channel state encoding,
// default timing constants and the elaboration-time range check.
package pumpa_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WAIT, ST_HOLD} state_t;

  localparam int DEF_FILL_CYCLES = 700_000_000;
  localparam int DEF_WAIT_CYCLES = 400_000_000;
  localparam int DEF_CNT_W       = 30;

  // True when a cycle count is non-zero and representable in a w-bit timer.
  function automatic bit fits(input longint unsigned v, input int w);
    return (v >= 64'd1) && (v < (64'd1 << w));
  endfunction

endpackage

// File: rtl/pumpa_kanali_if.sv
// Control/status bundle of the pump controller: operator inputs, sensors and outputs.
interface pumpa_kanali_if #(
  parameter int N_CH     = 2,
  parameter int BOTTLE_W = 16
) ();
  logic                en;
  logic [N_CH-1:0]     ir_pumpa;
  logic                fault_clr;
  logic [N_CH-1:0]     pumpa_switch;
  logic [N_CH-1:0]     dioda_punjenje;
  logic [N_CH-1:0]     fault;
  logic [BOTTLE_W-1:0] bottle_count;

  modport master (
    output en, ir_pumpa, fault_clr,
    input  pumpa_switch, dioda_punjenje, fault, bottle_count
  );

  modport slave (
    input  en, ir_pumpa, fault_clr,
    output pumpa_switch, dioda_punjenje, fault, bottle_count
  );
endinterface

// File: rtl/pumpa_kanal.sv
// One fill channel: sensor synchronizer, IDLE/FILL/WAIT/HOLD sequencer with its timer,
// registered pump/LED drive, sticky removal fault and a one-cycle completion pulse.
module pumpa_kanal
  import pumpa_pkg::*;
#(
  parameter int FILL_CYCLES = DEF_FILL_CYCLES,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ir,
  input  logic fault_clr,
  output logic pump,
  output logic led,
  output logic fault,
  output logic done
);

  if (!fits(longint'(FILL_CYCLES), CNT_W)) begin : g_bad_fill
    $error("FILL_CYCLES must be in 1..2**CNT_W-1");
  end
  if (!fits(longint'(WAIT_CYCLES), CNT_W)) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]       sync;
  logic             s;
  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             fault_ev, done_ev;

  assign s   = sync[1];
  assign led = pump;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      state <= ST_IDLE;
      timer <= '0;
      pump  <= 1'b1;
      fault <= 1'b0;
      done  <= 1'b0;
    end else begin
      sync  <= {sync[0], ir};
      state <= state_nx;
      timer <= timer_nx;
      // Outputs trail the state by one edge, so the pump follows FILL exactly.
      pump  <= (state != ST_FILL);
      fault <= (fault & ~fault_clr) | fault_ev;
      done  <= done_ev;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer + CNT_W'(1);
    fault_ev = 1'b0;
    done_ev  = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_nx = '0;
        if (!s && en) state_nx = ST_FILL;
      end
      ST_FILL: begin
        if (s) begin
          state_nx = ST_IDLE;
          timer_nx = '0;
          fault_ev = 1'b1;
        end else if (!en) begin
          state_nx = ST_HOLD;
          timer_nx = '0;
        end else if (timer == FILL_LAST) begin
          state_nx = ST_WAIT;
          timer_nx = '0;
          done_ev  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (s) begin
          state_nx = ST_IDLE;
          timer_nx = '0;
        end else if (timer == WAIT_LAST) begin
          state_nx = ST_HOLD;
          timer_nx = '0;
        end
      end
      ST_HOLD: begin
        // A filled bottle stays parked here until it is taken away.
        timer_nx = '0;
        if (s) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        timer_nx = '0;
      end
    endcase
  end

endmodule

// File: rtl/pumpa_kanali.sv
// Multi-channel bottle filler: N_CH independent channels plus the shared
// completed-fill counter.
module pumpa_kanali
  import pumpa_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int FILL_CYCLES = DEF_FILL_CYCLES,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BOTTLE_W    = 16
) (
  input logic          clk,
  input logic          rst,
  pumpa_kanali_if.slave bus
);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("N_CH must be in 1..8");
  end

  logic [N_CH-1:0]     pump, led, fault, done;
  logic [BOTTLE_W-1:0] count, inc;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pumpa_kanal #(
      .FILL_CYCLES (FILL_CYCLES),
      .WAIT_CYCLES (WAIT_CYCLES),
      .CNT_W       (CNT_W)
    ) u_kanal (
      .clk       (clk),
      .rst       (rst),
      .en        (bus.en),
      .ir        (bus.ir_pumpa[g]),
      .fault_clr (bus.fault_clr),
      .pump      (pump[g]),
      .led       (led[g]),
      .fault     (fault[g]),
      .done      (done[g])
    );
  end

  // Several channels may finish on the same edge; add them all at once.
  always_comb begin
    inc = '0;
    for (int i = 0; i < N_CH; i++) inc = inc + BOTTLE_W'(done[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count + inc;
  end

  assign bus.pumpa_switch   = pump;
  assign bus.dioda_punjenje = led;
  assign bus.fault          = fault;
  assign bus.bottle_count   = count;

endmodule

// File: tb/tb_pumpa_kanali.sv
// Bench for pumpa_kanali (2 channels, 10-cycle fill, 5-cycle settle, 4-bit count):
// directed scenarios with fixed timing plus a randomized run against a phase model.
module tb_pumpa_kanali;
  localparam int N_CH = 2, FILL = 10, WAITC = 5, BW = 4;

  logic clk = 1'b0, rst = 1'b1;
  int   n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  pumpa_kanali_if #(.N_CH(N_CH), .BOTTLE_W(BW)) bus ();

  pumpa_kanali #(
    .N_CH(N_CH), .FILL_CYCLES(FILL), .WAIT_CYCLES(WAITC), .CNT_W(8), .BOTTLE_W(BW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model: sensor delay line plus remaining-time counters per channel.
  bit       h1 [N_CH], h2 [N_CH], parked [N_CH], m_fault [N_CH];
  int       fill_left [N_CH], wait_left [N_CH];
  int       pending, m_count;
  bit [1:0] pump_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b1; bus.ir_pumpa = 2'b11; bus.fault_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      h1[c] = 1; h2[c] = 1; parked[c] = 0; m_fault[c] = 0;
      fill_left[c] = 0; wait_left[c] = 0;
    end
    pending = 0; m_count = 0; pump_exp = 2'b11;
  endtask

  task automatic model_step(input bit r, input bit e, input bit clr, input bit [1:0] ir);
    bit s;
    if (r) begin model_reset(); return; end
    m_count = (m_count + pending) % (1 << BW);
    pending = 0;
    for (int c = 0; c < N_CH; c++) begin
      s = h2[c];
      pump_exp[c] = !(fill_left[c] > 0);
      if (clr) m_fault[c] = 0;
      if (fill_left[c] > 0) begin
        if (s) begin fill_left[c] = 0; m_fault[c] = 1; end
        else if (!e) begin fill_left[c] = 0; parked[c] = 1; end
        else begin
          fill_left[c]--;
          if (fill_left[c] == 0) begin wait_left[c] = WAITC; pending++; end
        end
      end else if (wait_left[c] > 0) begin
        if (s) wait_left[c] = 0;
        else begin
          wait_left[c]--;
          if (wait_left[c] == 0) parked[c] = 1;
        end
      end else if (parked[c]) begin
        if (s) parked[c] = 0;
      end else if (!s && e) begin
        fill_left[c] = FILL;
      end
      h2[c] = h1[c];
      h1[c] = ir[c];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.ir_pumpa = 2'b00; bus.fault_clr = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ({bus.pumpa_switch, bus.dioda_punjenje, bus.fault, bus.bottle_count} !== {2'b11, 2'b11, 2'b00, 4'd0}) begin
      n_fail++;
      $display("FAIL reset sw=%b led=%b fault=%b cnt=%0d want 11 11 00 0",
               bus.pumpa_switch, bus.dioda_punjenje, bus.fault, bus.bottle_count);
    end
  endtask

  task automatic test_single_fill();
    do_reset();
    bus.ir_pumpa[0] = 1'b0;
    for (int e = 0; e <= 40; e++) begin
      tick();
      n_checks++;
      if (bus.pumpa_switch[0] !== ((e >= 3 && e <= 12) ? 1'b0 : 1'b1) ||
          bus.dioda_punjenje[0] !== bus.pumpa_switch[0] || bus.pumpa_switch[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_pump e=%0d sw=%b led=%b", e, bus.pumpa_switch, bus.dioda_punjenje);
      end
      if (e == 12 || e == 13 || e == 40) begin
        n_checks++;
        if (bus.bottle_count !== ((e == 12) ? 4'd0 : 4'd1)) begin
          n_fail++;
          $display("FAIL single_count e=%0d got=%0d", e, bus.bottle_count);
        end
      end
    end
  endtask

  task automatic test_dual_fill();
    do_reset();
    bus.ir_pumpa = 2'b00;
    for (int e = 0; e <= 16; e++) begin
      tick();
      n_checks++;
      if (bus.pumpa_switch !== ((e >= 3 && e <= 12) ? 2'b00 : 2'b11)) begin
        n_fail++;
        $display("FAIL dual_pump e=%0d got=%b", e, bus.pumpa_switch);
      end
      if (e == 12 || e == 13) begin
        n_checks++;
        if (bus.bottle_count !== ((e == 12) ? 4'd0 : 4'd2)) begin
          n_fail++;
          $display("FAIL dual_count e=%0d got=%0d", e, bus.bottle_count);
        end
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    bus.ir_pumpa[1] = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      n_checks++;
      if (bus.pumpa_switch !== {((e >= 3 && e <= 9) ? 1'b0 : 1'b1), 1'b1} ||
          bus.fault !== {(e >= 9), 1'b0} || bus.bottle_count !== 4'd0) begin
        n_fail++;
        $display("FAIL fault_abort e=%0d sw=%b fault=%b cnt=%0d", e, bus.pumpa_switch, bus.fault, bus.bottle_count);
      end
      if (e == 6) bus.ir_pumpa[1] = 1'b1;
    end
    bus.fault_clr = 1'b1; tick(); bus.fault_clr = 1'b0; tick();
    n_checks++;
    if (bus.fault !== 2'b00) begin
      n_fail++;
      $display("FAIL fault_clear got=%b want 00", bus.fault);
    end
    // Clear pulse lands on the same edge as a new removal event.
    bus.ir_pumpa[1] = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e >= 8) begin
        n_checks++;
        if (bus.fault[1] !== (e >= 9)) begin
          n_fail++;
          $display("FAIL fault_clr_collide e=%0d got=%b", e, bus.fault[1]);
        end
      end
      if (e == 6) bus.ir_pumpa[1] = 1'b1;
      if (e == 8) bus.fault_clr = 1'b1;
      if (e == 9) bus.fault_clr = 1'b0;
    end
  endtask

  task automatic test_en_abort();
    do_reset();
    bus.ir_pumpa[0] = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_checks++;
      if (bus.pumpa_switch[0] !== ((e >= 3 && e <= 6) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL en_abort e=%0d got=%b", e, bus.pumpa_switch[0]);
      end
      if (e == 5) bus.en = 1'b0;
      if (e == 7) bus.en = 1'b1;
    end
    repeat (30) tick();
    n_checks++;
    if (bus.pumpa_switch !== 2'b11 || bus.bottle_count !== 4'd0 || bus.fault !== 2'b00) begin
      n_fail++;
      $display("FAIL en_hold sw=%b cnt=%0d fault=%b want 11 0 00", bus.pumpa_switch, bus.bottle_count, bus.fault);
    end
    bus.ir_pumpa[0] = 1'b1; repeat (4) tick();
    bus.ir_pumpa[0] = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      tick();
      if (e >= 2) begin
        n_checks++;
        if (bus.pumpa_switch[0] !== (e == 2)) begin
          n_fail++;
          $display("FAIL en_restart e=%0d got=%b", e, bus.pumpa_switch[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill_wrap();
    do_reset();
    bus.ir_pumpa[0] = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus.pumpa_switch, bus.dioda_punjenje, bus.fault, bus.bottle_count} !== {2'b11, 2'b11, 2'b00, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_fill sw=%b led=%b fault=%b cnt=%0d", bus.pumpa_switch,
               bus.dioda_punjenje, bus.fault, bus.bottle_count);
    end
    rst = 1'b0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      n_checks++;
      if (bus.pumpa_switch[0] !== ((e >= 3) ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL post_reset_start e=%0d got=%b", e, bus.pumpa_switch[0]);
      end
    end
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      bus.ir_pumpa[0] = 1'b0; repeat (20) tick();
      bus.ir_pumpa[0] = 1'b1; repeat (4) tick();
      if (k >= 14) begin
        n_checks++;
        if (bus.bottle_count !== 4'(k % 16)) begin
          n_fail++;
          $display("FAIL wrap fill=%0d got=%0d want=%0d", k, bus.bottle_count, k % 16);
        end
      end
    end
  endtask

  task automatic test_random();
    bit [1:0] ir;
    bit       e, clr, r;
    int       errs;
    do_reset();
    model_reset();
    ir = 2'b11; errs = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N_CH; c++) if ($urandom_range(0, 24) == 0) ir[c] = ~ir[c];
      e   = ($urandom_range(0, 79) != 0);
      clr = ($urandom_range(0, 39) == 0);
      r   = ($urandom_range(0, 799) == 0);
      rst = r; bus.en = e; bus.fault_clr = clr; bus.ir_pumpa = ir;
      @(posedge clk);
      model_step(r, e, clr, ir);
      #1;
      n_checks++;
      if (bus.pumpa_switch !== pump_exp || bus.dioda_punjenje !== pump_exp ||
          bus.fault !== {m_fault[1], m_fault[0]} || bus.bottle_count !== 4'(m_count)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc=%0d sw=%b/%b led=%b fault=%b/%b cnt=%0d/%0d", cyc,
                   bus.pumpa_switch, pump_exp, bus.dioda_punjenje, bus.fault,
                   {m_fault[1], m_fault[0]}, bus.bottle_count, m_count);
      end
    end
    rst = 1'b0; bus.fault_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_dual_fill();
    test_fault();
    test_en_abort();
    test_reset_mid_fill_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pumpa_kanali.md
PUMPA_KANALI -- requirements
Module: pumpa_kanali

Interface
REQ-001 Parameter N_CH, default 2: number of independent fill channels (1..8).
REQ-002 Parameter FILL_CYCLES, default 700_000_000: pump-on duration per bottle, in clk cycles (>=1).
REQ-003 Parameter WAIT_CYCLES, default 400_000_000: post-fill settle duration, in clk cycles (>=1).
REQ-004 Parameter CNT_W, default 30: per-channel timer width; must hold max(FILL_CYCLES, WAIT_CYCLES).
REQ-005 Parameter BOTTLE_W, default 16: width of the completed-fill counter.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  high = new fills may start; low blocks starts and aborts active fills.
REQ-009 ir_pumpa  in  N_CH  per-channel IR bottle sensor, asynchronous, active-low (0 = bottle present).
REQ-010 fault_clr  in  1  single-cycle pulse clearing all fault bits.
REQ-011 pumpa_switch  out  N_CH  relay drive, active-low (0 = pump running).
REQ-012 dioda_punjenje  out  N_CH  indicator LED, 1 whenever the channel's pump is off.
REQ-013 fault  out  N_CH  sticky: bottle removed mid-fill.
REQ-014 bottle_count  out  BOTTLE_W  total completed fills, all channels.

Function
REQ-015 Each ir_pumpa bit shall pass a 2-flop synchronizer; the FSM shall use only the synchronized value (s).
REQ-016 Each channel shall run an FSM with states IDLE, FILL, WAIT, HOLD and one CNT_W-bit timer.
REQ-017 IDLE->FILL when s=0 and en=1; timer cleared.
REQ-018 Pump and LED outputs shall be registered Moore outputs: pumpa_switch=0 and dioda_punjenje=0 only in FILL; otherwise 1 and 1.
REQ-019 Latency: pumpa_switch falls on the 3rd rising edge after the first edge sampling ir_pumpa=0 (en high, channel IDLE).
REQ-020 FILL shall last exactly FILL_CYCLES cycles, then go to WAIT with the timer cleared.
REQ-021 WAIT shall last exactly WAIT_CYCLES cycles, then go to HOLD.
REQ-022 HOLD->IDLE only when s=1 (bottle gone); a bottle left in place shall never be refilled.
REQ-023 In WAIT, s=1 shall go directly to IDLE next edge.
REQ-024 In FILL, s=1 shall go to IDLE, turn the pump off next edge, and set fault for that channel.
REQ-025 In FILL, en=0 shall go to HOLD with the pump off next edge; no fault, no count.
REQ-026 When fault_clr and a new fault event occur in the same cycle, the fault bit shall end up set.
REQ-027 bottle_count shall increment on each FILL->WAIT transition, by the number of channels making that transition in the same cycle, and shall wrap modulo 2^BOTTLE_W.
REQ-028 Channels shall be fully independent; any combination of channels may pump simultaneously.

Reset
REQ-029 While rst=1 at an edge: all FSMs IDLE, timers 0, synchronizers 1, pumpa_switch all 1, dioda_punjenje all 1, fault 0, bottle_count 0.
REQ-030 Reset mid-FILL shall turn the pump off at that edge; no count, no fault.
REQ-031 After rst falls, a bottle already present with en=1 shall start a fill per REQ-019.

Structure
REQ-032 A shared package pumpa_pkg shall hold the state encoding and the default FILL_CYCLES, WAIT_CYCLES and CNT_W constants.
REQ-033 Sub-module pumpa_kanal shall contain one channel's synchronizer, FSM, timer and fault bit, and shall be instantiated N_CH times.
REQ-034 The top level shall hold only the bottle_count adder/register and the output concatenation.
REQ-035 Elaboration shall fail if FILL_CYCLES or WAIT_CYCLES is 0 or does not fit in CNT_W.

Verification (N_CH=2, FILL_CYCLES=10, WAIT_CYCLES=5, BOTTLE_W=4)
REQ-036 ir_pumpa[0] low at edge 0 and held, en=1 -> pumpa_switch[0] low at edges 3..12, high from edge 13; bottle_count=1 after edge 13; channel stays in HOLD with no second fill until ir_pumpa[0]=1.
REQ-037 Both sensors low on the same edge -> both pumps run identical windows; bottle_count steps 0->2 in one cycle.
REQ-038 ir_pumpa[1] high 5 cycles into FILL -> pumpa_switch[1]=1 three edges later; fault[1]=1; count unchanged; fault_clr pulse -> fault[1]=0.
REQ-039 en dropped mid-FILL -> pump off next edge; no count; no restart until bottle removed and reinserted with en=1.
REQ-040 rst pulsed mid-FILL -> all outputs at reset values at that edge; 16 successive fills -> bottle_count wraps 15->0.
